// File: rtl/fifo_rd_pkg.sv
// Shared encodings and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam int CNT_W = 16;

  // Frame counter width; a one-word frame still needs a 1-bit counter.
  function automatic int fcnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry {last,data} output buffer with its occupancy state machine.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         srst_i,
  input  logic         push_i,
  input  logic [W-1:0] entry_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] entry_o,
  output occ_e         state_o
);

  occ_e         state_q, state_d;
  logic         valid_q, valid_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         pop;

  assign pop     = valid_q & ready_i;
  assign valid_o = valid_q;
  assign entry_o = head_q;
  assign state_o = state_q;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (srst_i) begin
      state_d = ST_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_i) begin
            head_d  = entry_i;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push_i && !pop) begin
            skid_d  = entry_i;
            state_d = ST_TWO;
          end else if (push_i && pop) begin
            head_d = entry_i;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // No push can arrive here: RD is gated off while full.
          if (pop) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    valid_d = (state_d != ST_EMPTY);
  end

  // NOTE: the data registers are reset too, because m_data/m_last must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: pops a show-ahead FIFO into a valid/ready stream with frame tags.
// Optional accepted-word counter port rd_count is built when FIFO_RD_CNT_EN is defined.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int data_width = 8,
  parameter int frame_len  = 4
) (
  input  logic                  clk_RD,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  empty,
  input  logic [data_width-1:0] Q,
  output logic                  RD,
  output logic                  m_valid,
  output logic [data_width-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]      rd_count
`endif
);

  localparam int            FW       = fcnt_width(frame_len);
  localparam logic [FW-1:0] LAST_POS = FW'(frame_len - 1);

  occ_e                  state;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  last_tag;
  logic [data_width:0]   head_entry;

  // Gated by rst_n so the strobe is low for the whole reset, not just after the first edge.
  assign RD       = rst_n & ~empty & ~srst & (state != ST_TWO);
  assign last_tag = (fcnt_q == LAST_POS);

  always_comb begin
    fcnt_d = fcnt_q;
    if (srst) begin
      fcnt_d = '0;
    end else if (RD) begin
      fcnt_d = last_tag ? '0 : fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_RD or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  fifo_rd_skid #(
    .W(data_width + 1)
  ) u_skid (
    .clk    (clk_RD),
    .rst_n  (rst_n),
    .srst_i (srst),
    .push_i (RD),
    .entry_i({last_tag, Q}),
    .ready_i(m_ready),
    .valid_o(m_valid),
    .entry_o(head_entry),
    .state_o(state)
  );

  assign m_last = head_entry[data_width];
  assign m_data = head_entry[data_width-1:0];

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (srst) begin
      cnt_d = '0;
    end else if (m_valid && m_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_RD or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: directed vector table, queue-based reference model, async reset corners.
module tb_fifo_rd_stream;

  logic clk_RD = 1'b0;
  always #5 clk_RD = ~clk_RD;

  logic       rst_n, srst, empty, m_ready;
  logic [7:0] Q;
  logic       rd4, rd1, rd3, v4, v1, v3, l4, l1, l3;
  logic [7:0] d4, d1, d3;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] c4, c1, c3;
`endif

  fifo_rd_stream #(.data_width(8), .frame_len(4)) dut (
    .clk_RD(clk_RD), .rst_n(rst_n), .srst(srst), .empty(empty), .Q(Q), .RD(rd4),
    .m_valid(v4), .m_data(d4), .m_last(l4), .m_ready(m_ready)
`ifdef FIFO_RD_CNT_EN
    , .rd_count(c4)
`endif
  );
  fifo_rd_stream #(.data_width(8), .frame_len(1)) dut1 (
    .clk_RD(clk_RD), .rst_n(rst_n), .srst(srst), .empty(empty), .Q(Q), .RD(rd1),
    .m_valid(v1), .m_data(d1), .m_last(l1), .m_ready(m_ready)
`ifdef FIFO_RD_CNT_EN
    , .rd_count(c1)
`endif
  );
  fifo_rd_stream #(.data_width(8), .frame_len(3)) dut3 (
    .clk_RD(clk_RD), .rst_n(rst_n), .srst(srst), .empty(empty), .Q(Q), .RD(rd3),
    .m_valid(v3), .m_data(d3), .m_last(l3), .m_ready(m_ready)
`ifdef FIFO_RD_CNT_EN
    , .rd_count(c3)
`endif
  );

  typedef struct {
    int         idx;   // words pushed since the last clear, 0-based
    logic [7:0] data;
  } ent_t;

  typedef struct {
    bit         e;
    logic [7:0] q;
    bit         rdy;
    bit         sr;
    bit         rd;
    bit         v;
    logic [7:0] d;
    bit         l;
  } vec_t;

  ent_t       buf_q[$];
  logic [7:0] src_q[$];
  int         idx_m, cnt_m, rd_hits;
  int         checks, errors;
  vec_t       vt[19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_last(input ent_t e, input int len);
    return (e.idx % len) == (len - 1);
  endfunction

  task automatic clear_model();
    buf_q.delete();
    idx_m = 0;
    cnt_m = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd4"}, rd4, 0);  check({tag, " rd1"}, rd1, 0);  check({tag, " rd3"}, rd3, 0);
    check({tag, " v4"}, v4, 0);    check({tag, " v1"}, v1, 0);    check({tag, " v3"}, v3, 0);
    check({tag, " d4"}, d4, 0);    check({tag, " d1"}, d1, 0);    check({tag, " d3"}, d3, 0);
    check({tag, " l4"}, l4, 0);    check({tag, " l1"}, l1, 0);    check({tag, " l3"}, l3, 0);
`ifdef FIFO_RD_CNT_EN
    check({tag, " cnt4"}, c4, 0);  check({tag, " cnt1"}, c1, 0);  check({tag, " cnt3"}, c3, 0);
`endif
  endtask

  // Compare every DUT against the queue model; expected RD comes from buffer fullness.
  task automatic check_outputs(output bit er);
    ent_t h;
    bit   ev;
    er = rst_n && !empty && !srst && (buf_q.size() < 2);
    ev = buf_q.size() > 0;
    check("rd4", rd4, er); check("rd1", rd1, er); check("rd3", rd3, er);
    check("v4", v4, ev);   check("v1", v1, ev);   check("v3", v3, ev);
    if (ev) begin
      h = buf_q[0];
      check("d4", d4, h.data); check("d1", d1, h.data); check("d3", d3, h.data);
      check("l4", l4, exp_last(h, 4));
      check("l1", l1, exp_last(h, 1));
      check("l3", l3, exp_last(h, 3));
    end
`ifdef FIFO_RD_CNT_EN
    check("cnt4", c4, cnt_m[15:0]);
    check("cnt3", c3, cnt_m[15:0]);
`endif
  endtask

  task automatic drive(input bit rdy, input bit sr);
    srst    = sr;
    m_ready = rdy;
    empty   = (src_q.size() == 0);
    Q       = empty ? 8'($urandom) : src_q[0];
  endtask

  // One model-checked cycle; entered and left at posedge+1.
  task automatic cycle(input bit rdy, input bit sr);
    bit   er;
    ent_t e;
    drive(rdy, sr);
    #2;
    check_outputs(er);
    if (er) rd_hits++;
    if (sr) begin
      clear_model();
    end else begin
      if (buf_q.size() > 0 && rdy) begin
        void'(buf_q.pop_front());
        cnt_m++;
      end
      if (er) begin
        e.idx  = idx_m;
        e.data = Q;
        buf_q.push_back(e);
        idx_m++;
        void'(src_q.pop_front());
      end
    end
    @(posedge clk_RD);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    srst    = 1'b0;
    m_ready = 1'b0;
    empty   = 1'b0;
    Q       = 8'hAA;
    #3;
    check_all_zero("reset");
    clear_model();
    src_q.delete();
    @(posedge clk_RD);
    #1;
    rst_n = 1'b1;
  endtask

  // rst_n dropped between edges: outputs must clear before any clock arrives.
  task automatic do_async_reset(input bit rdy);
    bit er;
    drive(rdy, 1'b0);
    #2;
    check_outputs(er);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    clear_model();
    @(posedge clk_RD);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_hits = 0;

    // Back-pressure with 5 words queued, then srst while full.
    vt[0]  = '{1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0};
    vt[2]  = '{1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0};
    vt[3]  = '{1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0};
    vt[4]  = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0};
    vt[5]  = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vt[6]  = '{1'b0, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0};
    vt[7]  = '{1'b0, 8'h14, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 1'b1};
    vt[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14, 1'b0};
    vt[9]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[10] = '{1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[11] = '{1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0};
    vt[12] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0};
    vt[13] = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[14] = '{1'b0, 8'h23, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
    vt[15] = '{1'b0, 8'h24, 1'b1, 1'b0, 1'b1, 1'b1, 8'h23, 1'b0};
    vt[16] = '{1'b0, 8'h25, 1'b1, 1'b0, 1'b1, 1'b1, 8'h24, 1'b0};
    vt[17] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h25, 1'b1};
    vt[18] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    do_reset();

    for (int i = 0; i < 19; i++) begin
      empty   = vt[i].e;
      Q       = vt[i].q;
      m_ready = vt[i].rdy;
      srst    = vt[i].sr;
      #2;
      check($sformatf("vec%0d rd", i), rd4, vt[i].rd);
      check($sformatf("vec%0d valid", i), v4, vt[i].v);
      if (vt[i].v) begin
        check($sformatf("vec%0d data", i), d4, vt[i].d);
        check($sformatf("vec%0d last", i), l4, vt[i].l);
      end
`ifdef FIFO_RD_CNT_EN
      if (i == 13) check("cnt after srst", c4, 0);
`endif
      @(posedge clk_RD);
      #1;
    end

    // Preload 8 words with the sink always ready.
    do_reset();
    for (int w = 0; w < 8; w++) src_q.push_back(8'(8'h10 + w));
    rd_hits = 0;
    for (int c = 0; c < 12; c++) cycle(1'b1, 1'b0);
    check("preload rd pulses", rd_hits, 8);
    check("preload accepted", cnt_m, 8);
    check("preload drained", buf_q.size(), 0);

    // Random traffic, occasional srst and mid-frame async reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 3) != 0 && src_q.size() < 6) src_q.push_back(8'($urandom));
      if ((c % 700) == 350) do_async_reset(1'($urandom));
      else cycle(1'(($urandom % 4) != 0 ? $urandom : 0), ($urandom % 97) == 0);
    end

`ifdef FIFO_RD_CNT_EN
    // Counter wrap: 0x10002 accepted words.
    do_reset();
    for (int c = 0; c < 32'h10010 && cnt_m < 32'h10002; c++) begin
      while (src_q.size() < 3) src_q.push_back(8'($urandom));
      cycle(1'b1, 1'b0);
    end
    check("wrap accepted", cnt_m, 32'h10002);
    check("wrap rd_count", c4, 16'h0002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
